tlb_fa: RTL and testbench

Fully-associative, parametrised translation buffer; the next generation of the processor's fixed lookup table. It translates processor virtual addresses to physical addresses for the memory path. On a miss it raises a fill handshake toward the page-table walker and installs the returned entry. It adds dirty tracking, round-robin replacement, eviction notification, flush, and hit/miss statistics.

---
 rtl/tlb_fa.sv | 178 +++++++++++++++++
 tb/tb_tlb_fa.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_fa.sv
// Fully-associative translation buffer: VPN->PPN lookup with miss/fill handshake,
// dirty tracking, round-robin replacement, eviction notice, flush and hit/miss counters.
//
//   state  | meaning
//   IDLE   | ready for a request; req_ready=1
//   LOOKUP | latched VPN compared against all valid entries
//   MISS   | miss_valid held, waiting for fill_valid from the walker
module tlb_fa #(
    parameter int VA_W    = 16,
    parameter int PA_W    = 16,
    parameter int OFF_W   = 8,
    parameter int ENTRIES = 8,
    parameter int CNT_W   = 16
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  req_valid,
    input  logic [VA_W-1:0]       req_vaddr,
    input  logic                  req_write,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [PA_W-1:0]       resp_paddr,
    output logic                  resp_hit,
    output logic                  resp_fault,
    output logic                  miss_valid,
    output logic [VA_W-OFF_W-1:0] miss_vpn,
    input  logic                  fill_valid,
    input  logic [PA_W-OFF_W-1:0] fill_ppn,
    input  logic                  fill_fault,
    output logic                  evict_valid,
    output logic [VA_W-OFF_W-1:0] evict_vpn,
    output logic                  evict_dirty,
    input  logic                  flush,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    localparam int VPN_W = VA_W - OFF_W;
    localparam int PPN_W = PA_W - OFF_W;
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS} state_t;

    state_t             state, state_nxt;
    logic [VPN_W-1:0]   tag_vpn [ENTRIES];
    logic [PPN_W-1:0]   tag_ppn [ENTRIES];
    logic [ENTRIES-1:0] ent_valid, ent_dirty;
    logic [IDX_W-1:0]   rr_ptr;
    logic [VA_W-1:0]    vaddr_q;
    logic               write_q;

    logic               hit_any, free_any, install;
    logic [IDX_W-1:0]   hit_idx, free_idx, victim_idx;
    logic [ENTRIES-1:0] victim_mask;
    logic [VPN_W-1:0]   lk_vpn;
    logic [OFF_W-1:0]   lk_off;

    assign lk_vpn    = vaddr_q[VA_W-1:OFF_W];
    assign lk_off    = vaddr_q[OFF_W-1:0];
    assign req_ready = (state == IDLE);

    // Descending scans so the lowest matching / free index is the one left standing.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_valid[i] && (tag_vpn[i] == lk_vpn)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!ent_valid[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign victim_idx  = free_any ? free_idx : rr_ptr;
    assign victim_mask = ENTRIES'(1) << victim_idx;
    assign install     = (state == MISS) && fill_valid && !fill_fault;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = hit_any ? IDLE : MISS;
            MISS:    if (fill_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_vpn[i] <= '0;
                tag_ppn[i] <= '0;
            end
            ent_valid   <= '0;
            ent_dirty   <= '0;
            rr_ptr      <= '0;
            vaddr_q     <= '0;
            write_q     <= 1'b0;
            resp_valid  <= 1'b0;
            resp_paddr  <= '0;
            resp_hit    <= 1'b0;
            resp_fault  <= 1'b0;
            miss_valid  <= 1'b0;
            miss_vpn    <= '0;
            evict_valid <= 1'b0;
            evict_vpn   <= '0;
            evict_dirty <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            resp_valid  <= 1'b0;
            evict_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        vaddr_q <= req_vaddr;
                        write_q <= req_write;
                    end
                end
                LOOKUP: begin
                    if (hit_any) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_paddr <= {tag_ppn[hit_idx], lk_off};
                        if (write_q) ent_dirty[hit_idx] <= 1'b1;
                        if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + CNT_W'(1);
                    end else begin
                        miss_valid <= 1'b1;
                        miss_vpn   <= lk_vpn;
                        if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + CNT_W'(1);
                    end
                end
                MISS: begin
                    if (fill_valid) begin
                        miss_valid <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_fault <= fill_fault;
                        resp_paddr <= fill_fault ? '0 : {fill_ppn, lk_off};
                        if (!fill_fault) begin
                            tag_vpn[victim_idx]   <= lk_vpn;
                            tag_ppn[victim_idx]   <= fill_ppn;
                            ent_valid[victim_idx] <= 1'b1;
                            ent_dirty[victim_idx] <= write_q;
                            if (!free_any) begin
                                evict_valid <= 1'b1;
                                evict_vpn   <= tag_vpn[victim_idx];
                                evict_dirty <= ent_dirty[victim_idx];
                                rr_ptr      <= rr_ptr + IDX_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
            // Flush overrides table updates above; a coincident install is the only survivor.
            if (flush) begin
                ent_valid   <= install ? victim_mask : '0;
                ent_dirty   <= (install && write_q) ? victim_mask : '0;
                rr_ptr      <= '0;
                evict_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tlb_fa.sv
// Self-checking bench for tlb_fa: directed scenarios plus randomized traffic
// checked against a transaction-level model of the translation table.
module tb_tlb_fa;
    localparam int ENTRIES = 8;
    localparam int CNT_W   = 5;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        req_valid, req_write, req_ready;
    logic [15:0] req_vaddr;
    logic        resp_valid, resp_hit, resp_fault;
    logic [15:0] resp_paddr;
    logic        miss_valid;
    logic [7:0]  miss_vpn;
    logic        fill_valid, fill_fault;
    logic [7:0]  fill_ppn;
    logic        evict_valid, evict_dirty;
    logic [7:0]  evict_vpn;
    logic        flush;
    logic [CNT_W-1:0] hit_count, miss_count;

    tlb_fa #(.VA_W(16), .PA_W(16), .OFF_W(8), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .req_valid(req_valid), .req_vaddr(req_vaddr), .req_write(req_write), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_hit(resp_hit), .resp_fault(resp_fault),
        .miss_valid(miss_valid), .miss_vpn(miss_vpn),
        .fill_valid(fill_valid), .fill_ppn(fill_ppn), .fill_fault(fill_fault),
        .evict_valid(evict_valid), .evict_vpn(evict_vpn), .evict_dirty(evict_dirty),
        .flush(flush), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Model of the table contents
    bit        m_valid [ENTRIES];
    bit        m_dirty [ENTRIES];
    bit [7:0]  m_vpn   [ENTRIES];
    bit [7:0]  m_ppn   [ENTRIES];
    int        m_rr, m_hits, m_misses;
    bit [15:0] m_paddr;

    // DUT eviction outputs captured at the response cycle, for directed checks
    logic       ev_seen, ev_dirty_got;
    logic [7:0] ev_vpn_got;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_vpn[i] = 0; m_ppn[i] = 0;
        end
        m_rr = 0; m_hits = 0; m_misses = 0; m_paddr = 0;
    endtask

    task automatic m_flush();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0;
        end
        m_rr = 0;
    endtask

    function automatic int m_find(input bit [7:0] vpn);
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_vpn[i] == vpn) return i;
        return -1;
    endfunction

    function automatic int sat(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    task automatic chk_counts(input string nm);
        chk({nm, "_hit_count"}, 32'(hit_count), 32'(m_hits));
        chk({nm, "_miss_count"}, 32'(miss_count), 32'(m_misses));
    endtask

    // fmode: 0 none, 1 flush on lookup edge, 2 flush on fill edge, 3 flush during miss wait
    task automatic do_req(input bit [15:0] va, input bit wr, input int fmode, input int delay,
                          input bit [7:0] ppn, input bit fault);
        bit [7:0]  vpn;
        int        hidx, v;
        bit        ev_exp, ev_d;
        bit [7:0]  ev_v;
        vpn = va[15:8];
        ev_exp = 0; ev_d = 0; ev_v = 0;
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1; req_vaddr = va; req_write = wr;
        @(posedge Clock); #1;
        req_valid = 0;
        chk("req_ready_lookup", 32'(req_ready), 0);
        chk("resp_valid_lookup", 32'(resp_valid), 0);
        hidx = m_find(vpn);
        if (fmode == 1) flush = 1;
        @(posedge Clock); #1;
        flush = 0;
        if (hidx >= 0) begin
            m_paddr = {m_ppn[hidx], va[7:0]};
            m_hits = sat(m_hits);
            if (wr) m_dirty[hidx] = 1;
            if (fmode == 1) m_flush();
            chk("hit_resp_valid", 32'(resp_valid), 1);
            chk("hit_resp_hit", 32'(resp_hit), 1);
            chk("hit_resp_fault", 32'(resp_fault), 0);
            chk("hit_paddr", 32'(resp_paddr), 32'(m_paddr));
            chk("hit_miss_valid", 32'(miss_valid), 0);
            chk("hit_evict_valid", 32'(evict_valid), 0);
            chk("hit_req_ready", 32'(req_ready), 1);
            chk_counts("hit");
        end else begin
            m_misses = sat(m_misses);
            if (fmode == 1) m_flush();
            chk("miss_valid", 32'(miss_valid), 1);
            chk("miss_vpn", 32'(miss_vpn), 32'(vpn));
            chk("miss_resp_valid", 32'(resp_valid), 0);
            chk("miss_req_ready", 32'(req_ready), 0);
            chk_counts("miss");
            for (int c = 0; c < delay; c++) begin
                if (fmode == 3 && c == 0) flush = 1;
                @(posedge Clock); #1;
                if (flush) begin
                    flush = 0;
                    m_flush();
                end
                chk("miss_hold", 32'(miss_valid), 1);
                chk("miss_wait_resp", 32'(resp_valid), 0);
            end
            fill_valid = 1; fill_ppn = ppn; fill_fault = fault;
            if (fmode == 2) flush = 1;
            @(posedge Clock); #1;
            fill_valid = 0; flush = 0;
            v = -1;
            if (!fault) begin
                for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) v = i;
                if (v < 0) begin
                    v = m_rr;
                    ev_exp = 1; ev_v = m_vpn[v]; ev_d = m_dirty[v];
                    m_rr = (m_rr + 1) % ENTRIES;
                end
                m_vpn[v] = vpn; m_ppn[v] = ppn; m_valid[v] = 1; m_dirty[v] = wr;
            end
            if (fmode == 2) begin
                m_flush();
                ev_exp = 0;
                if (v >= 0) begin
                    m_valid[v] = 1; m_dirty[v] = wr;
                end
            end
            m_paddr = fault ? 16'h0 : {ppn, va[7:0]};
            chk("fill_resp_valid", 32'(resp_valid), 1);
            chk("fill_resp_hit", 32'(resp_hit), 0);
            chk("fill_resp_fault", 32'(resp_fault), 32'(fault));
            chk("fill_paddr", 32'(resp_paddr), 32'(m_paddr));
            chk("fill_miss_valid", 32'(miss_valid), 0);
            chk("fill_req_ready", 32'(req_ready), 1);
            chk("evict_valid", 32'(evict_valid), 32'(ev_exp));
            if (ev_exp) begin
                chk("evict_vpn", 32'(evict_vpn), 32'(ev_v));
                chk("evict_dirty", 32'(evict_dirty), 32'(ev_d));
            end
            chk_counts("fill");
        end
        ev_seen = evict_valid; ev_vpn_got = evict_vpn; ev_dirty_got = evict_dirty;
        @(posedge Clock); #1;
        chk("pulse_resp_valid", 32'(resp_valid), 0);
        chk("pulse_evict_valid", 32'(evict_valid), 0);
        chk("paddr_hold", 32'(resp_paddr), 32'(m_paddr));
        chk("idle_miss_valid", 32'(miss_valid), 0);
    endtask

    task automatic pulse_flush();
        flush = 1;
        @(posedge Clock); #1;
        flush = 0;
        m_flush();
        chk("flush_req_ready", 32'(req_ready), 1);
    endtask

    int mc_before;

    initial begin
        Resetn = 0; req_valid = 0; req_vaddr = 0; req_write = 0;
        fill_valid = 0; fill_ppn = 0; fill_fault = 0; flush = 0;
        m_reset();
        #22;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_miss_valid", 32'(miss_valid), 0);
        chk("rst_evict_valid", 32'(evict_valid), 0);
        chk("rst_paddr", 32'(resp_paddr), 0);
        chk_counts("rst");
        @(negedge Clock); Resetn = 1;
        @(posedge Clock); #1;

        // Cold miss then hit with store
        do_req(16'h1234, 0, 0, 2, 8'h56, 0);
        chk("cold_paddr_lit", 32'(resp_paddr), 32'h5634);
        chk("cold_miss_count_lit", 32'(miss_count), 1);
        do_req(16'h12FF, 1, 0, 0, 8'h00, 0);
        chk("hit_paddr_lit", 32'(resp_paddr), 32'h56FF);
        chk("hit_count_lit", 32'(hit_count), 1);

        // Fill the table, forcing dirty 0x12 out, then round-robin victims
        for (int i = 0; i < 8; i++) do_req({8'(i), 8'h10}, 0, 0, 1, 8'(8'hA0 + i), 0);
        chk("evict_dirty12_seen", 32'(ev_seen), 1);
        chk("evict_dirty12_vpn", 32'(ev_vpn_got), 32'h12);
        chk("evict_dirty12_dirty", 32'(ev_dirty_got), 1);
        do_req(16'h0800, 0, 0, 1, 8'hB8, 0);
        chk("evict_08_vpn", 32'(ev_vpn_got), 32'h00);
        chk("evict_08_dirty", 32'(ev_dirty_got), 0);
        do_req(16'h0900, 0, 0, 1, 8'hB9, 0);
        chk("evict_09_vpn", 32'(ev_vpn_got), 32'h01);

        // Fault, then the same VPN misses again
        do_req(16'h4000, 0, 0, 2, 8'h77, 1);
        chk("fault_flag_lit", 32'(resp_fault), 1);
        chk("fault_paddr_lit", 32'(resp_paddr), 0);
        mc_before = int'(miss_count);
        do_req(16'h4000, 0, 0, 1, 8'h44, 0);
        chk("fault_rereq_miss", 32'(miss_count), 32'(mc_before + 1));

        // Flush behaviour
        do_req(16'h1200, 0, 0, 1, 8'h21, 0);
        pulse_flush();
        do_req(16'h1200, 0, 0, 1, 8'h22, 0);
        chk("post_flush_miss", 32'(resp_hit), 0);
        do_req(16'h0500, 1, 0, 1, 8'h55, 0);
        do_req(16'h3300, 1, 2, 1, 8'h33, 0);
        do_req(16'h3311, 0, 0, 0, 8'h00, 0);
        chk("flush_fill_survivor_hit", 32'(resp_hit), 1);
        chk("flush_fill_survivor_paddr", 32'(resp_paddr), 32'h3311);
        do_req(16'h1200, 0, 0, 1, 8'h23, 0);
        chk("flush_fill_other_miss", 32'(resp_hit), 0);
        do_req(16'h1201, 1, 1, 0, 8'h00, 0);
        do_req(16'h6600, 0, 3, 2, 8'h66, 0);

        // Reset while a miss is pending; a late fill must be ignored
        req_valid = 1; req_vaddr = 16'h7700; req_write = 0;
        @(posedge Clock); #1; req_valid = 0;
        @(posedge Clock); #1;
        chk("pre_reset_miss_valid", 32'(miss_valid), 1);
        Resetn = 0; #1;
        m_reset();
        chk("rst_mid_miss_valid", 32'(miss_valid), 0);
        chk("rst_mid_req_ready", 32'(req_ready), 1);
        chk_counts("rst_mid");
        @(negedge Clock); Resetn = 1;
        @(posedge Clock); #1;
        fill_valid = 1; fill_ppn = 8'h99;
        @(posedge Clock); #1;
        fill_valid = 0;
        chk("late_fill_resp_valid", 32'(resp_valid), 0);
        @(posedge Clock); #1;
        chk("late_fill_resp_valid2", 32'(resp_valid), 0);
        chk("late_fill_req_ready", 32'(req_ready), 1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            bit [15:0] va;
            int        fm, r;
            va = {8'($urandom_range(0, 13)), 8'($urandom)};
            r  = $urandom_range(0, 19);
            fm = (r < 4) ? r : 0;
            if ($urandom_range(0, 29) == 0) pulse_flush();
            do_req(va, 1'($urandom), fm, $urandom_range(1, 3), 8'($urandom),
                   ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
